// File: rtl/riscv_axi_rd_arb.sv
// Two-requester round-robin AXI4 read arbiter (requester 0 = LSU, 1 = IFU), one burst in flight.
// Optional R-channel inactivity timeout with SLVERR completion and drain: define RISCV_RDARB_TIMEOUT_EN.
module riscv_axi_rd_arb #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          s_arvalid,
    output logic [1:0]          s_arready,
    input  logic [2*ADDR_W-1:0] s_araddr,
    input  logic [15:0]         s_arlen,
    output logic [1:0]          s_rvalid,
    input  logic [1:0]          s_rready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic                m_arid,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    output logic                proto_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
`ifdef RISCV_RDARB_TIMEOUT_EN
        DRAIN = 2'd3,
`endif
        DATA  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                grant_c;
    logic                ar_hs_c;
    logic                r_hs_c;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          len_q;
    logic [7:0]          beat_q;
    logic                gnt_q;
    logic                last_grant_q;
    logic                proto_err_q;
    logic                tmo_c;

`ifdef RISCV_RDARB_TIMEOUT_EN
    logic [15:0] tmo_q;
    assign tmo_c = (state_q == DATA) && (tmo_q == 16'(TIMEOUT_CYCLES));
`else
    logic unused_tmo_param;
    assign unused_tmo_param = |TIMEOUT_CYCLES;
    assign tmo_c = 1'b0;
`endif

    // Round-robin pick: on a tie the requester not served last wins
    always_comb begin
        case (s_arvalid)
            2'b10:   grant_c = 1'b1;
            2'b11:   grant_c = ~last_grant_q;
            default: grant_c = 1'b0;
        endcase
    end

    assign ar_hs_c = (state_q == IDLE) && (|s_arvalid);
    assign r_hs_c  = m_rvalid && m_rready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ar_hs_c) state_d = ADDR;
            ADDR: if (m_arready) state_d = DATA;
            DATA: begin
                if (tmo_c) begin
                    if (s_rready[gnt_q]) begin
`ifdef RISCV_RDARB_TIMEOUT_EN
                        state_d = DRAIN;
`endif
                    end
                end else if (r_hs_c && m_rlast) begin
                    state_d = IDLE;
                end
            end
`ifdef RISCV_RDARB_TIMEOUT_EN
            DRAIN: if (m_rvalid && m_rlast) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Channel routing; R payload passes straight through except for the synthesized timeout beat
    always_comb begin
        s_arready = 2'b00;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        s_rvalid  = 2'b00;
        s_rdata   = m_rdata;
        s_rresp   = m_rresp;
        s_rlast   = m_rlast;
        case (state_q)
            IDLE: s_arready[grant_c] = |s_arvalid;
            ADDR: m_arvalid = 1'b1;
            DATA: begin
                if (tmo_c) begin
                    s_rvalid[gnt_q] = 1'b1;
                    s_rresp         = 2'b10;
                    s_rlast         = 1'b1;
                    s_rdata         = '0;
                end else begin
                    s_rvalid[gnt_q] = m_rvalid;
                    m_rready        = s_rready[gnt_q];
                end
            end
`ifdef RISCV_RDARB_TIMEOUT_EN
            DRAIN: m_rready = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q       <= '0;
            len_q        <= 8'd0;
            gnt_q        <= 1'b0;
            beat_q       <= 8'd0;
            last_grant_q <= 1'b1;
            proto_err_q  <= 1'b0;
        end else begin
            if (ar_hs_c) begin
                addr_q <= grant_c ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
                len_q  <= grant_c ? s_arlen[15:8] : s_arlen[7:0];
                gnt_q  <= grant_c;
                beat_q <= 8'd0;
            end
            if (state_q == DATA && r_hs_c) begin
                beat_q <= beat_q + 8'd1;
                // RLAST must land exactly on beat arlen; routing still obeys RLAST
                if (m_rlast != (beat_q == len_q)) proto_err_q <= 1'b1;
                if (m_rlast) last_grant_q <= gnt_q;
            end
`ifdef RISCV_RDARB_TIMEOUT_EN
            if (state_q == DRAIN && m_rvalid && m_rlast) last_grant_q <= gnt_q;
`endif
        end
    end

`ifdef RISCV_RDARB_TIMEOUT_EN
    // Inactivity counter saturates at the limit so the error beat stays presented
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_q <= 16'd0;
        end else if (state_q == DATA) begin
            if (r_hs_c)                           tmo_q <= 16'd0;
            else if (tmo_q != 16'(TIMEOUT_CYCLES)) tmo_q <= tmo_q + 16'd1;
        end else begin
            tmo_q <= 16'd0;
        end
    end
`endif

    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_arid    = gnt_q;
    assign proto_err = proto_err_q;

endmodule
